muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset is synchronous and active-high.
REQ-004 SHALL have port ctrl_valid  input  1  control word and operands valid this cycle.
REQ-005 SHALL have port control  input  11  decoded control word {enable,regwrite,alu_control[3:0],alusrc,memread,memwrite,branch,memtoreg}, bits 10..0.
REQ-006 SHALL have port rs1_data  input  32  operand A (multiplicand/dividend).
REQ-007 SHALL have port rs2_data  input  32  operand B (multiplier/divisor).
REQ-008 SHALL have port rd_in  input  5  destination register tag.
REQ-009 SHALL have port flush  input  1  abort in-flight operation.
REQ-010 SHALL have port busy  output  1  unit not IDLE.
REQ-011 SHALL have port result_valid  output  1  one-cycle result strobe.
REQ-012 SHALL have port result  output  32  M-extension result.
REQ-013 SHALL have port rd_out  output  5  tag of the completed operation.

Function
REQ-014 SHALL accept an operation on an edge where state==IDLE, ctrl_valid=1, control[10]=0, control[9]=1, control[8]=0, flush=0; otherwise no accept.
REQ-015 SHALL decode op=control[7:5]: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU; control[8]=1 is illegal and ignored.
REQ-016 SHALL on accept capture op, rd_in, absolute/raw operands, result sign flags, and clear iteration counter to 0.
REQ-017 SHALL implement states IDLE, CALC, FIX, DONE: IDLE->CALC on accept; CALC->FIX after the 32nd iteration (counter==31); FIX->DONE unconditionally; DONE->IDLE unconditionally.
REQ-018 SHALL in CALC perform one radix-2 step per cycle: shift-add multiply (64-bit product) or restoring divide (32-bit quotient, 32-bit remainder) on unsigned magnitudes.
REQ-019 SHALL in FIX apply sign correction and select: MUL low 32, MULH/MULHSU/MULHU high 32, DIV/DIVU quotient, REM/REMU remainder; register result, rd_out, result_valid=1.
REQ-020 SHALL treat signedness: MULH both signed, MULHSU rs1 signed/rs2 unsigned, MULHU/DIVU/REMU unsigned, DIV/REM signed; remainder takes dividend sign.
REQ-021 SHALL for divisor 0 produce quotient 0xFFFFFFFF and remainder = dividend, with normal latency.
REQ-022 SHALL for signed 0x80000000 / 0xFFFFFFFF produce quotient 0x80000000 and remainder 0, with normal latency.
REQ-023 SHALL assert result_valid for exactly one cycle, visible after the 33rd rising edge following the accepting edge (fixed latency, all ops).
REQ-024 SHALL hold result and rd_out stable from FIX until the next FIX; result_valid=0 otherwise.
REQ-025 SHALL drive busy=1 in CALC, FIX, DONE; upstream holds the instruction while busy; ctrl_valid during busy is ignored.
REQ-026 SHALL on flush=1 go to IDLE at that edge, suppress any pending result_valid, and not accept; flush in IDLE has no effect beyond blocking accept.
REQ-027 SHALL give reset priority over flush, flush priority over accept.

Reset
REQ-028 SHALL on reset=1 at an edge set state=IDLE, busy=0, result_valid=0, result=0, rd_out=0, counter=0, regardless of in-flight work.
REQ-029 SHALL accept a new operation on the first edge after reset deasserts.

Verification
REQ-030 SHALL cover MUL rs1=7, rs2=0xFFFFFFFD, rd_in=5 -> result=0xFFFFFFEB, rd_out=5, result_valid 33 edges after accept.
REQ-031 SHALL cover MULH 0x80000000x0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFFx0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFFx0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 SHALL cover DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same operands -> 0; DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF.
REQ-033 SHALL cover DIVU 100/0 -> 0xFFFFFFFF, REMU 100/0 -> 0x00000064.
REQ-034 SHALL cover flush at CALC iteration 10 -> no result_valid, busy=0 next cycle, following DIVU 9/2 -> 4 with full latency.
REQ-035 SHALL cover reset mid-CALC and non-M control words (control[10]=1, or control[8]=1) -> busy stays 0, no result_valid.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32 M-extension multiply/divide unit.
//
// One radix-2 step per cycle on unsigned magnitudes (shift-add multiply,
// restoring divide), then a sign-fix cycle. The latency is fixed: result_valid
// pulses for one cycle, 33 rising edges after the accepting edge.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   ctrl_valid   in   control word and operands valid this cycle
//   control      in   {enable,regwrite,alu_control[3:0],alusrc,memread,memwrite,branch,memtoreg}
//   rs1_data     in   operand A (multiplicand / dividend)
//   rs2_data     in   operand B (multiplier / divisor)
//   rd_in        in   destination register tag
//   flush        in   abort any in-flight operation
//   busy         out  unit not idle
//   result_valid out  one-cycle result strobe
//   result       out  M-extension result, held until the next completion
//   rd_out       out  tag of the completed operation
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ctrl_valid,
    input  logic [10:0]     control,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int unsigned DW   = 2 * XLEN;
    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [DW-1:0]     acc_q, acc_d;        // mul: {hi, multiplier}; div: {rem, quot}
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              neg_q, neg_d;        // negate product / quotient
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic              valid_q, valid_d;

    logic [2:0]        op_in;
    logic              accept;
    logic              is_mul_in;
    logic              a_signed, b_signed;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              b_zero;
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_diff;
    logic [DW-1:0]     prod_fix;
    logic [XLEN-1:0]   quot, rem;
    logic [XLEN-1:0]   fix_result;
    logic              unused_bits;

    assign op_in  = control[7:5];
    assign accept = (state_q == StIdle) && ctrl_valid && !control[10] && control[9]
                    && !control[8] && !flush;

    // Operand signedness: MULH both, MULHSU rs1 only, DIV/REM both.
    assign is_mul_in = !op_in[2];
    assign a_signed  = (op_in == 3'd1) || (op_in == 3'd2) || (op_in == 3'd4) || (op_in == 3'd6);
    assign b_signed  = (op_in == 3'd1) || (op_in == 3'd4) || (op_in == 3'd6);
    assign sign_a    = a_signed && rs1_data[XLEN-1];
    assign sign_b    = b_signed && rs2_data[XLEN-1];
    assign abs_a     = sign_a ? -rs1_data : rs1_data;
    assign abs_b     = sign_b ? -rs2_data : rs2_data;
    assign b_zero    = (rs2_data == '0);

    // Shift-add multiply step: add multiplicand into the high half, shift right.
    assign mul_sum  = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Restoring divide step: trial subtract from the left-shifted partial remainder.
    assign div_diff = {1'b0, acc_q[DW-1:XLEN-1]} - {2'b0, opnd_q};

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quot     = acc_q[XLEN-1:0];
    assign rem      = acc_q[DW-1:XLEN];

    always_comb begin
        fix_result = '0;
        unique case (op_q)
            3'd0:                fix_result = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fix_result = prod_fix[DW-1:XLEN];
            3'd4, 3'd5:          fix_result = neg_q ? -quot : quot;
            3'd6, 3'd7:          fix_result = neg_rem_q ? -rem : rem;
            default:             fix_result = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        valid_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StCalc;
                    op_d      = op_in;
                    rd_d      = rd_in;
                    opnd_d    = is_mul_in ? abs_a : abs_b;
                    acc_d     = {{XLEN{1'b0}}, (is_mul_in ? abs_b : abs_a)};
                    cnt_d     = '0;
                    // Divide by zero keeps the all-ones quotient unsigned.
                    neg_d     = (sign_a ^ sign_b) && (is_mul_in || !b_zero);
                    neg_rem_d = sign_a;
                end
            end
            StCalc: begin
                if (!op_q[2]) begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end else if (!div_diff[XLEN+1]) begin
                    acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[DW-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(XLEN - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d  = StDone;
                result_d = fix_result;
                rd_out_d = rd_q;
                valid_d  = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Flush aborts everything in flight, including a completion on this edge.
        if (flush) begin
            state_d  = StIdle;
            valid_d  = 1'b0;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            rd_q      <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
            valid_q   <= valid_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign result_valid = valid_q;
    assign result       = result_q;
    assign rd_out       = rd_out_q;

    // Low control bits are non-M fields; div_diff[XLEN] is always 0 after a
    // successful trial subtract.
    assign unused_bits = ^{control[4:0], div_diff[XLEN]};

endmodule
